// File: rtl/amci_pkg.sv
// rtl/amci_pkg.sv - AMCI bus field offsets, widths and AXI response codes
package amci_pkg;

  typedef logic [1:0] amci_resp_t;
  typedef enum logic {CLIENT_C0 = 1'b0, CLIENT_C1 = 1'b1} amci_client_e;

  localparam amci_resp_t RESP_OKAY   = 2'd0;
  localparam amci_resp_t RESP_EXOKAY = 2'd1;
  localparam amci_resp_t RESP_SLVERR = 2'd2;
  localparam amci_resp_t RESP_DECERR = 2'd3;

  function automatic int mosi_w(input int aw, input int dw);
    return 2 * aw + dw + 2;
  endfunction

  function automatic int miso_w(input int dw);
    return dw + 6;
  endfunction

  function automatic int mosi_wdata_off(input int aw);
    return aw;
  endfunction

  function automatic int mosi_raddr_off(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int mosi_write_bit(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction

  function automatic int mosi_read_bit(input int aw, input int dw);
    return 2 * aw + dw + 1;
  endfunction

  function automatic int miso_widle_bit(input int dw);
    return dw;
  endfunction

  function automatic int miso_ridle_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int miso_wresp_off(input int dw);
    return dw + 2;
  endfunction

  function automatic int miso_rresp_off(input int dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/amci_arbiter2_if.sv
// rtl/amci_arbiter2_if.sv - one AMCI port: packed request bus and packed status/response bus
interface amci_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import amci_pkg::*;

  logic [mosi_w(AW, DW)-1:0] mosi;
  logic [miso_w(DW)-1:0]     miso;

  // master drives requests toward the AXI FSMs; slave is what a client controller talks to
  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);

endinterface

// File: rtl/amci_arb_channel.sv
// rtl/amci_arb_channel.sv - two-client capture, round-robin grant and IDLE/ACK/DONE sequencing for one AMCI channel
module amci_arb_channel #(
  parameter int REQ_W = 64,
  parameter int RSP_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c0_req,
  input  logic [REQ_W-1:0] c0_payload,
  output logic             c0_idle,
  output logic [RSP_W-1:0] c0_rsp,
  input  logic             c1_req,
  input  logic [REQ_W-1:0] c1_payload,
  output logic             c1_idle,
  output logic [RSP_W-1:0] c1_rsp,
  output logic             m_req,
  output logic [REQ_W-1:0] m_payload,
  input  logic             m_idle,
  input  logic [RSP_W-1:0] m_rsp
);
  import amci_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       idle_q;
  amci_client_e     grant;
  amci_client_e     ptr;
  logic [REQ_W-1:0] hold0;
  logic [REQ_W-1:0] hold1;

  logic [1:0]       take;
  logic [1:0]       avail;
  logic [REQ_W-1:0] payload0;
  logic [REQ_W-1:0] payload1;
  amci_client_e     pick;

  assign c0_idle = idle_q[0];
  assign c1_idle = idle_q[1];

  // A strobe arriving this cycle is already eligible, so issue can happen at T+1.
  always_comb begin
    take     = {c1_req & idle_q[1], c0_req & idle_q[0]};
    avail    = ~idle_q | take;
    payload0 = idle_q[0] ? c0_payload : hold0;
    payload1 = idle_q[1] ? c1_payload : hold1;
    pick     = CLIENT_C0;
    if (avail == 2'b11) begin
      pick = ptr;
    end else if (avail[1]) begin
      pick = CLIENT_C1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idle_q    <= 2'b11;
      grant     <= CLIENT_C0;
      ptr       <= CLIENT_C0;
      hold0     <= '0;
      hold1     <= '0;
      c0_rsp    <= '0;
      c1_rsp    <= '0;
      m_req     <= 1'b0;
      m_payload <= '0;
    end else begin
      m_req <= 1'b0;
      if (take[0]) begin
        hold0     <= c0_payload;
        idle_q[0] <= 1'b0;
      end
      if (take[1]) begin
        hold1     <= c1_payload;
        idle_q[1] <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (m_idle && (avail != 2'b00)) begin
            m_req     <= 1'b1;
            m_payload <= (pick == CLIENT_C1) ? payload1 : payload0;
            grant     <= pick;
            if (avail == 2'b11) begin
              ptr <= (pick == CLIENT_C0) ? CLIENT_C1 : CLIENT_C0;
            end
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!m_idle) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // the granted client cannot be capturing now, so releasing it here never collides
          if (m_idle) begin
            if (grant == CLIENT_C1) begin
              c1_rsp    <= m_rsp;
              idle_q[1] <= 1'b1;
            end else begin
              c0_rsp    <= m_rsp;
              idle_q[0] <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/amci_arbiter2.sv
// rtl/amci_arbiter2.sv - shares one AMCI master port between two client controllers, write and read arbitrated independently
module amci_arbiter2 #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input logic            CLK,
  input logic            RESETN,
  amci_arbiter2_if.slave  C0_AMCI,
  amci_arbiter2_if.slave  C1_AMCI,
  amci_arbiter2_if.master AMCI
);
  import amci_pkg::*;

  localparam int AW      = AXI_ADDR_WIDTH;
  localparam int DW      = AXI_DATA_WIDTH;
  localparam int WREQ_W  = AW + DW;
  localparam int RRSP_W  = DW + 2;
  localparam int WDATA_O = mosi_wdata_off(AW);
  localparam int RADDR_O = mosi_raddr_off(AW, DW);
  localparam int WRITE_B = mosi_write_bit(AW, DW);
  localparam int READ_B  = mosi_read_bit(AW, DW);
  localparam int WIDLE_B = miso_widle_bit(DW);
  localparam int RIDLE_B = miso_ridle_bit(DW);
  localparam int WRESP_O = miso_wresp_off(DW);
  localparam int RRESP_O = miso_rresp_off(DW);

  logic              c0_widle, c1_widle, c0_ridle, c1_ridle;
  amci_resp_t        c0_wresp, c1_wresp;
  logic [RRSP_W-1:0] c0_rrsp, c1_rrsp;
  logic              m_write, m_read;
  logic [WREQ_W-1:0] m_wpay;
  logic [AW-1:0]     m_raddr;

  // write payload is {wdata, waddr} so it drops straight back into the MOSI layout
  amci_arb_channel #(.REQ_W(WREQ_W), .RSP_W(2)) u_wr_channel (
    .clk        (CLK),
    .rst_n      (RESETN),
    .c0_req     (C0_AMCI.mosi[WRITE_B]),
    .c0_payload ({C0_AMCI.mosi[WDATA_O +: DW], C0_AMCI.mosi[0 +: AW]}),
    .c0_idle    (c0_widle),
    .c0_rsp     (c0_wresp),
    .c1_req     (C1_AMCI.mosi[WRITE_B]),
    .c1_payload ({C1_AMCI.mosi[WDATA_O +: DW], C1_AMCI.mosi[0 +: AW]}),
    .c1_idle    (c1_widle),
    .c1_rsp     (c1_wresp),
    .m_req      (m_write),
    .m_payload  (m_wpay),
    .m_idle     (AMCI.miso[WIDLE_B]),
    .m_rsp      (AMCI.miso[WRESP_O +: 2])
  );

  // read response is {rresp, rdata}
  amci_arb_channel #(.REQ_W(AW), .RSP_W(RRSP_W)) u_rd_channel (
    .clk        (CLK),
    .rst_n      (RESETN),
    .c0_req     (C0_AMCI.mosi[READ_B]),
    .c0_payload (C0_AMCI.mosi[RADDR_O +: AW]),
    .c0_idle    (c0_ridle),
    .c0_rsp     (c0_rrsp),
    .c1_req     (C1_AMCI.mosi[READ_B]),
    .c1_payload (C1_AMCI.mosi[RADDR_O +: AW]),
    .c1_idle    (c1_ridle),
    .c1_rsp     (c1_rrsp),
    .m_req      (m_read),
    .m_payload  (m_raddr),
    .m_idle     (AMCI.miso[RIDLE_B]),
    .m_rsp      ({AMCI.miso[RRESP_O +: 2], AMCI.miso[0 +: DW]})
  );

  assign AMCI.mosi    = {m_read, m_write, m_raddr, m_wpay};
  assign C0_AMCI.miso = {c0_rrsp[DW +: 2], c0_wresp, c0_ridle, c0_widle, c0_rrsp[0 +: DW]};
  assign C1_AMCI.miso = {c1_rrsp[DW +: 2], c1_wresp, c1_ridle, c1_widle, c1_rrsp[0 +: DW]};

endmodule

// File: tb/tb_amci_arbiter2.sv
// tb/tb_amci_arbiter2.sv - directed self-checking bench for amci_arbiter2 with a latency-based AXI slave model
module tb_amci_arbiter2;
  import amci_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amci_arbiter2_if #(.AW(AW), .DW(DW)) c0_if ();
  amci_arbiter2_if #(.AW(AW), .DW(DW)) c1_if ();
  amci_arbiter2_if #(.AW(AW), .DW(DW)) m_if ();

  amci_arbiter2 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .CLK     (clk),
    .RESETN  (rst_n),
    .C0_AMCI (c0_if),
    .C1_AMCI (c1_if),
    .AMCI    (m_if)
  );

  logic          c0_wr = 1'b0, c0_rd = 1'b0, c1_wr = 1'b0, c1_rd = 1'b0;
  logic [AW-1:0] c0_waddr = '0, c0_raddr = '0, c1_waddr = '0, c1_raddr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;

  assign c0_if.mosi = {c0_rd, c0_wr, c0_raddr, c0_wdata, c0_waddr};
  assign c1_if.mosi = {c1_rd, c1_wr, c1_raddr, c1_wdata, c1_waddr};

  logic          c0_widle, c0_ridle, c1_widle, c1_ridle;
  logic [1:0]    c0_wresp, c0_rresp, c1_wresp, c1_rresp;
  logic [DW-1:0] c0_rdata, c1_rdata;
  assign c0_rdata = c0_if.miso[0 +: DW];
  assign c0_widle = c0_if.miso[DW];
  assign c0_ridle = c0_if.miso[DW+1];
  assign c0_wresp = c0_if.miso[DW+2 +: 2];
  assign c0_rresp = c0_if.miso[DW+4 +: 2];
  assign c1_rdata = c1_if.miso[0 +: DW];
  assign c1_widle = c1_if.miso[DW];
  assign c1_ridle = c1_if.miso[DW+1];
  assign c1_wresp = c1_if.miso[DW+2 +: 2];
  assign c1_rresp = c1_if.miso[DW+4 +: 2];

  logic [AW-1:0] m_waddr, m_raddr;
  logic [DW-1:0] m_wdata;
  logic          m_write, m_read;
  assign m_waddr = m_if.mosi[0 +: AW];
  assign m_wdata = m_if.mosi[AW +: DW];
  assign m_raddr = m_if.mosi[AW+DW +: AW];
  assign m_write = m_if.mosi[2*AW+DW];
  assign m_read  = m_if.mosi[2*AW+DW+1];

  // Slave model: write completes 5 cycles after acceptance, read after 3; response chosen by address
  logic          s_widle = 1'b1, s_ridle = 1'b1;
  logic [1:0]    s_wresp = 2'd0, s_rresp = 2'd0;
  logic [DW-1:0] s_rdata = '0;
  logic [AW-1:0] s_wa = '0, s_ra = '0;
  int            wcnt = 0, rcnt = 0;
  int            wr_pulses = 0, overlap = 0;
  logic [AW-1:0] wlog[$];
  assign m_if.miso = {s_rresp, s_wresp, s_ridle, s_widle, s_rdata};

  function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
    case (a)
      32'h10:  return RESP_EXOKAY;
      32'h20:  return RESP_SLVERR;
      32'h40:  return RESP_SLVERR;
      32'h50:  return RESP_EXOKAY;
      32'h70:  return RESP_DECERR;
      default: return RESP_OKAY;
    endcase
  endfunction

  always @(posedge clk) begin
    if (m_write) begin
      wr_pulses <= wr_pulses + 1;
      if (!s_widle) overlap <= overlap + 1;
    end
    if (m_write && s_widle) begin
      wlog.push_back(m_waddr);
      s_widle <= 1'b0;
      s_wa    <= m_waddr;
      wcnt    <= 5;
    end else if (!s_widle) begin
      if (wcnt == 0) begin
        s_widle <= 1'b1;
        s_wresp <= resp_for(s_wa);
      end else begin
        wcnt <= wcnt - 1;
      end
    end
    if (m_read && s_ridle) begin
      s_ridle <= 1'b0;
      s_ra    <= m_raddr;
      rcnt    <= 3;
    end else if (!s_ridle) begin
      if (rcnt == 0) begin
        s_ridle <= 1'b1;
        s_rresp <= resp_for(s_ra);
        s_rdata <= 32'hCAFEF00D;
      end else begin
        rcnt <= rcnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic idle_of(input int which);
    case (which)
      0:       return c0_widle;
      1:       return c1_widle;
      2:       return c0_ridle;
      default: return c1_ridle;
    endcase
  endfunction

  task automatic wait_idle(input int which, input string tag);
    int n = 0;
    while (!idle_of(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
  endtask

  int pulses_before;
  int n0, n1, guard;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_c0_widle", c0_widle, 1);
    chk("rst_c0_ridle", c0_ridle, 1);
    chk("rst_c1_widle", c1_widle, 1);
    chk("rst_c1_ridle", c1_ridle, 1);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_c0_wresp", c0_wresp, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write from C0
    c0_waddr = 32'h1000; c0_wdata = 32'hDEADBEEF; c0_wr = 1'b1;
    @(negedge clk);
    c0_wr = 1'b0;
    chk("single_m_write", m_write, 1);
    chk("single_m_waddr", m_waddr, 32'h1000);
    chk("single_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("single_c0_widle", c0_widle, 0);
    chk("single_c1_widle", c1_widle, 1);
    @(negedge clk);
    chk("single_pulse_end", m_write, 0);
    chk("single_addr_stable", m_waddr, 32'h1000);
    wait_idle(0, "single_done");
    chk("single_c0_wresp", c0_wresp, RESP_OKAY);
    chk("single_pulses", wr_pulses, 1);
    chk("single_c1_wresp", c1_wresp, 0);

    // simultaneous writes
    wlog.delete();
    c0_waddr = 32'h10; c0_wdata = 32'h11111111; c0_wr = 1'b1;
    c1_waddr = 32'h20; c1_wdata = 32'h22222222; c1_wr = 1'b1;
    @(negedge clk);
    c0_wr = 1'b0; c1_wr = 1'b0;
    chk("sim_first_waddr", m_waddr, 32'h10);
    chk("sim_first_wdata", m_wdata, 32'h11111111);
    chk("sim_c1_waiting", c1_widle, 0);
    wait_idle(0, "sim_c0_done");
    wait_idle(1, "sim_c1_done");
    chk("sim_count", wlog.size(), 2);
    chk("sim_order0", wlog[0], 32'h10);
    chk("sim_order1", wlog[1], 32'h20);
    chk("sim_c0_wresp", c0_wresp, RESP_EXOKAY);
    chk("sim_c1_wresp", c1_wresp, RESP_SLVERR);
    chk("sim_overlap", overlap, 0);

    // concurrent write and read channels
    c0_waddr = 32'h30; c0_wdata = 32'h33333333; c0_wr = 1'b1;
    c1_raddr = 32'h40; c1_rd = 1'b1;
    @(negedge clk);
    c0_wr = 1'b0; c1_rd = 1'b0;
    chk("conc_m_write", m_write, 1);
    chk("conc_m_read", m_read, 1);
    chk("conc_m_waddr", m_waddr, 32'h30);
    chk("conc_m_raddr", m_raddr, 32'h40);
    wait_idle(0, "conc_c0_done");
    wait_idle(3, "conc_c1_done");
    chk("conc_c1_rdata", c1_rdata, 32'hCAFEF00D);
    chk("conc_c1_rresp", c1_rresp, RESP_SLVERR);
    chk("conc_c0_wresp", c0_wresp, RESP_OKAY);
    chk("conc_c1_wresp", c1_wresp, RESP_SLVERR);
    chk("conc_c0_rdata", c0_rdata, 0);

    // protocol violation: second strobe while busy is ignored
    pulses_before = wr_pulses;
    c1_waddr = 32'h50; c1_wdata = 32'h55555555; c1_wr = 1'b1;
    @(negedge clk);
    c1_waddr = 32'h60; c1_wdata = 32'h66666666;
    chk("viol_c1_busy", c1_widle, 0);
    @(negedge clk);
    c1_wr = 1'b0;
    wait_idle(1, "viol_done");
    repeat (10) @(negedge clk);
    chk("viol_pulses", wr_pulses - pulses_before, 1);
    chk("viol_last_addr", wlog[$], 32'h50);
    chk("viol_c1_wresp", c1_wresp, RESP_EXOKAY);
    chk("viol_c1_idle", c1_widle, 1);

    // reset while the master transaction is in flight
    pulses_before = wr_pulses;
    c0_waddr = 32'h70; c0_wdata = 32'h77777777; c0_wr = 1'b1;
    @(negedge clk);
    c0_wr = 1'b0;
    chk("rmf_issue", m_write, 1);
    @(negedge clk);
    chk("rmf_c0_busy", c0_widle, 0);
    rst_n = 1'b0;
    #1;
    chk("rmf_m_write", m_write, 0);
    chk("rmf_m_waddr", m_waddr, 0);
    chk("rmf_c0_widle", c0_widle, 1);
    chk("rmf_c1_wresp", c1_wresp, 0);
    chk("rmf_c1_rdata", c1_rdata, 0);
    chk("rmf_c1_rresp", c1_rresp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rmf_c0_wresp", c0_wresp, RESP_OKAY);
    chk("rmf_c0_idle_after", c0_widle, 1);
    chk("rmf_pulses", wr_pulses - pulses_before, 1);
    chk("rmf_m_quiet", m_write, 0);

    // fairness: both clients re-request on every completion
    wlog.delete();
    n0 = 0; n1 = 0; guard = 0;
    while ((n0 < 8 || n1 < 8 || !c0_widle || !c1_widle) && guard < 2000) begin
      c0_wr = c0_widle && (n0 < 8);
      if (c0_wr) begin
        c0_waddr = 32'h100 + 32'(n0); c0_wdata = 32'(n0); n0++;
      end
      c1_wr = c1_widle && (n1 < 8);
      if (c1_wr) begin
        c1_waddr = 32'h200 + 32'(n1); c1_wdata = 32'(n1); n1++;
      end
      @(negedge clk);
      guard++;
    end
    c0_wr = 1'b0; c1_wr = 1'b0;
    chk("fair_timeout", 64'(guard < 2000), 1);
    chk("fair_count", wlog.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fair_order%0d", k), wlog[k],
          (k % 2 == 0) ? 64'(32'h100 + k / 2) : 64'(32'h200 + k / 2));
    end
    chk("fair_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amci_arbiter2.md
Name: amci_arbiter2

Overview:
- Shares one AMCI master port (the AXI4-Lite master FSM pair) between two AMCI client controllers, C0 and C1.
- The write and read channels are arbitrated independently, each round-robin.
- Each client sees a standard AMCI slave-side interface, with its own idle and response signals, so unmodified controllers plug in.
- Sits between the controllers and the AXI master FSM.

Parameters:
- AXI_DATA_WIDTH, 32, data width of the AMCI/AXI path.
- AXI_ADDR_WIDTH, 32, address width of the AMCI/AXI path.
- Derived: MOSI_W = 2*AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 2 (98 at defaults); MISO_W = AXI_DATA_WIDTH + 6 (38 at defaults).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESETN  in  1  reset; asynchronous, active-low.
- C0_AMCI_MOSI  in  MOSI_W  client 0 requests.
- C0_AMCI_MISO  out  MISO_W  client 0 status and responses.
- C1_AMCI_MOSI  in  MOSI_W  client 1 requests.
- C1_AMCI_MISO  out  MISO_W  client 1 status and responses.
- AMCI_MOSI  out  MOSI_W  to the AXI master FSMs.
- AMCI_MISO  in  MISO_W  from the AXI master FSMs.

Behaviour:
- Bit packing, identical on all MOSI/MISO buses:
  - MOSI: waddr[0+:AW], wdata[AW+:DW], raddr[AW+DW+:AW], write[2AW+DW], read[2AW+DW+1].
  - MISO: rdata[0+:DW], widle[DW], ridle[DW+1], wresp[DW+2+:2], rresp[DW+4+:2].
- Reset values (asserted asynchronously on RESETN low):
  - Master side: write=0, read=0, waddr/wdata/raddr=0.
  - Each client: widle=1, ridle=1, wresp=0, rresp=0, rdata=0.
  - Both round-robin pointers favour C0. All pending requests cleared.
- All outputs are registered.
- Per-client capture (write channel; the read channel is identical using read/raddr/ridle/rresp/rdata):
  - Client write=1 in cycle T while its widle=1: waddr/wdata latch into a 1-deep holding register, pending=1, and client widle=0 from T+1.
  - Client write=1 while its widle=0: protocol violation; ignored, no state change.
- Channel FSM, one instance per channel:
  - IDLE: if master widle=1 and any pending, grant one client.
    - Only one pending: grant it.
    - Both pending: grant the pointer's client, then set the pointer to the other client.
    - Drive master waddr/wdata from the holding register, write=1 for exactly one cycle, go to ACK.
    - Earliest issue is T+1, where T is the client strobe cycle.
  - ACK: wait for master widle=0, then go to DONE. Master address/data stay stable.
  - DONE: wait for master widle=1, then next cycle:
    - Granted client's wresp = master wresp (rresp and rdata for reads).
    - Client widle=1; pending cleared; go to IDLE.
    - Response values hold until that client's next completion.
- Arbitration rules:
  - A new grant may issue the cycle after DONE exits, giving one dead cycle between master transactions.
  - A client strobe landing in the same cycle as its own completion is impossible, because its widle was 0.
  - The other client's strobe in any cycle is captured normally.
  - Write and read channels run concurrently. C0 writing while C1 reads does not block either.
  - The client not granted keeps widle=0 until its own transaction completes; its response fields are untouched.
- Fairness: with both clients re-requesting continuously, grants alternate strictly C0, C1, C0, ...
- Error responses (SLVERR=2, DECERR=3) pass through unchanged; the arbiter does not retry.
- Reset mid-transaction: the FSM returns to IDLE and pending requests are dropped. The master may complete the in-flight AXI transaction, and its response is discarded.

Decomposition:
- Shared package amci_pkg: MOSI/MISO offset functions of AW/DW, MOSI_W/MISO_W, and AXI resp constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- One sub-module, amci_arb_channel: 2-client capture, round-robin pointer and IDLE/ACK/DONE FSM, parameterized by request payload width (AW+DW for writes, AW for reads) and response width (2 for writes, 2+DW for reads).
- Instantiated twice in amci_arbiter2, which only slices and concatenates the buses.

Test Plan:
- Reset: RESETN low mid-run -> all outputs at reset values immediately; both client widle/ridle=1; master write/read=0.
- Single write: C0 write waddr=0x1000, wdata=0xDEADBEEF; slave model answers OKAY after 5 cycles -> master write pulse 1 cycle at T+1 with those values; C0 widle=0 from T+1, back to 1 with wresp=0; C1 untouched.
- Simultaneous writes: C0 (0x10, 0x11111111) and C1 (0x20, 0x22222222) in the same cycle -> master sees 0x10 first, then 0x20; second pulse only after master widle returns to 1; each client gets its own wresp.
- Fairness: both clients re-request immediately on each completion for 8 rounds -> master grant order C0, C1, C0, C1 ...; no client starves.
- Concurrent channels: C0 write to 0x30 plus C1 read of 0x40 in the same cycle, slave returning rdata=0xCAFEF00D with rresp=SLVERR -> both master strobes in the same cycle; C1 rdata=0xCAFEF00D, rresp=2; C0 wresp=0.
- Protocol violation and reset mid-flight: C1 strobes write while its widle=0 -> no extra master write. Assert RESETN during ACK -> FSM back to IDLE, late master response not routed to any client.
